// File: rtl/pe18_psum_accum.sv
// Partial-sum drain stage for one PE-array column. Each accepted beat
// carries LANES signed IN_W-bit lanes. The stage accumulates them over
// len_q beats into saturating ACC_W-bit sums, then hands the sums out
// over a valid/ready interface.
module pe18_psum_accum #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    pe_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        len_q;
    logic [ACC_W-1:0]        acc     [LANES];
    logic [ACC_W-1:0]        acc_nxt [LANES];
    logic signed [SUM_W-1:0] sum_ext [LANES];
    logic [LANES*ACC_W-1:0]  sum_packed;
    logic                    sat_q;
    logic                    beat_clamp;
    logic                    last_beat;
    logic                    accept;
    logic                    start_ok;

    assign start_ok  = (state == IDLE) && start && (cfg_len != '0);
    assign last_beat = (cnt == len_q - CNT_W'(1));
    // The final beat may only land when the output register is free or draining now.
    assign in_ready  = en && (state == ACC) && !(last_beat && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == ACC);

    // Per-lane sign-extended add with clamp to the signed ACC_W range.
    always_comb begin
        beat_clamp = 1'b0;
        sum_packed = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_ext[i] = SUM_W'($signed(acc[i])) + SUM_W'($signed(pe_out[i*IN_W +: IN_W]));
            acc_nxt[i] = sum_ext[i][ACC_W-1:0];
            if (sum_ext[i][SUM_W-1] != sum_ext[i][SUM_W-2]) begin
                beat_clamp = 1'b1;
                acc_nxt[i] = sum_ext[i][SUM_W-1] ? ACC_MIN : ACC_MAX;
            end
            sum_packed[i*ACC_W +: ACC_W] = acc_nxt[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave IDLE on a valid start, return after the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = ACC;
            ACC:  if (accept && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulators, beat counter and the registered output holding the finished job.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            len_q     <= '0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (start_ok) begin
                len_q <= cfg_len;
                cnt   <= '0;
                sat_q <= 1'b0;
                for (int i = 0; i < LANES; i++) acc[i] <= '0;
            end
            if (accept) begin
                if (last_beat) begin
                    out_data  <= sum_packed;
                    out_ovf   <= sat_q | beat_clamp;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    sat_q     <= 1'b0;
                    for (int i = 0; i < LANES; i++) acc[i] <= '0;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    sat_q <= sat_q | beat_clamp;
                    for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pe18_psum_accum.sv
// Scoreboard bench for pe18_psum_accum: the stimulus pushes the expected
// results, and the monitors pop and compare them on each output transfer.
module tb_pe18_psum_accum;

    localparam int unsigned LANES   = 4;
    localparam int unsigned IN_W    = 16;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned S_ACC_W = 18;

    typedef struct packed {
        logic [127:0] data;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset, en;
    logic                     start, in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
    logic [CNT_W-1:0]         cfg_len;
    logic [LANES*IN_W-1:0]    pe_out;
    logic [LANES*ACC_W-1:0]   out_data;

    logic                     s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf, s_busy;
    logic [CNT_W-1:0]         s_cfg_len;
    logic [LANES*IN_W-1:0]    s_pe_out;
    logic [LANES*S_ACC_W-1:0] s_out_data;

    exp_t q[$];
    exp_t q18[$];
    exp_t m_e, m_e18;
    int   vectors = 0;
    int   miscompares = 0;

    pe18_psum_accum #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .pe_out(pe_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    pe18_psum_accum #(.LANES(LANES), .IN_W(IN_W), .ACC_W(S_ACC_W), .CNT_W(CNT_W)) dut18 (
        .clk(clk), .reset(reset), .en(en), .start(s_start), .cfg_len(s_cfg_len),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .pe_out(s_pe_out),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_ovf(s_out_ovf), .busy(s_busy)
    );

    function automatic logic [63:0] in4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] lanes4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] lanes18(input logic [17:0] a, b, c, d);
        return 128'({d, c, b, a});
    endfunction

    function automatic exp_t mk(input logic [127:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got %0h expected none", out_data);
            end else begin
                m_e = q.pop_front();
                check("out_data", 128'(out_data), m_e.data);
                check("out_ovf", 128'(out_ovf), 128'(m_e.ovf));
            end
        end
    end

    // Monitor for the 18-bit saturation instance.
    always @(negedge clk) begin
        #2;
        if (s_out_valid === 1'b1 && s_out_ready === 1'b1) begin
            if (q18.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result18: got %0h expected none", s_out_data);
            end else begin
                m_e18 = q18.pop_front();
                check("out_data18", 128'(s_out_data), m_e18.data);
                check("out_ovf18", 128'(s_out_ovf), 128'(m_e18.ovf));
            end
        end
    end

    task automatic do_start(input logic [CNT_W-1:0] len);
        start   = 1'b1;
        cfg_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        logic hs;
        int   n;
        n        = 0;
        in_valid = 1'b1;
        pe_out   = d;
        forever begin
            #1;
            hs = in_ready;
            @(posedge clk);
            if (hs) break;
            @(negedge clk);
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_timeout: got no in_ready expected accept within 100 cycles");
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic s_send_beat(input logic [63:0] d);
        logic hs;
        int   n;
        n          = 0;
        s_in_valid = 1'b1;
        s_pe_out   = d;
        forever begin
            #1;
            hs = s_in_ready;
            @(posedge clk);
            if (hs) break;
            @(negedge clk);
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_timeout18: got no in_ready expected accept within 100 cycles");
                break;
            end
        end
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; pe_out = '0; out_ready = 1'b1;
        s_start = 1'b0; s_cfg_len = '0; s_in_valid = 1'b0; s_pe_out = '0; s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_ovf", 128'(out_ovf), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic job: 100 + 200 - 50 = 250 on every lane.
        q.push_back(mk(lanes4(32'd250, 32'd250, 32'd250, 32'd250), 1'b0));
        do_start(16'd3);
        send_beat(in4(16'd100, 16'd100, 16'd100, 16'd100));
        send_beat(in4(16'd200, 16'd200, 16'd200, 16'd200));
        send_beat(in4(16'hFFCE, 16'hFFCE, 16'hFFCE, 16'hFFCE));
        #1;
        check("basic_out_valid", 128'(out_valid), 128'(1));
        check("basic_busy", 128'(busy), 128'(0));

        // Lane independence and sign extension.
        q.push_back(mk(lanes4(32'd65534, 32'hFFFF0000, 32'd2, 32'hFFFFFFFE), 1'b0));
        do_start(16'd2);
        send_beat(in4(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF));
        send_beat(in4(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF));

        // Backpressure: job A pending while job B's final beat arrives.
        @(negedge clk);
        out_ready = 1'b0;
        q.push_back(mk(lanes4(32'd5, 32'd5, 32'd5, 32'd5), 1'b0));
        do_start(16'd1);
        send_beat(in4(16'd5, 16'd5, 16'd5, 16'd5));
        q.push_back(mk(lanes4(32'd14, 32'd14, 32'd14, 32'd14), 1'b0));
        do_start(16'd2);
        send_beat(in4(16'd7, 16'd7, 16'd7, 16'd7));
        in_valid = 1'b1;
        pe_out   = in4(16'd7, 16'd7, 16'd7, 16'd7);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready_low", 128'(in_ready), 128'(0));
            check("bp_hold_data", 128'(out_data), lanes4(32'd5, 32'd5, 32'd5, 32'd5));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_out_valid_kept", 128'(out_valid), 128'(1));
        check("bp_new_data", 128'(out_data), lanes4(32'd14, 32'd14, 32'd14, 32'd14));
        @(negedge clk);

        // en gating mid-job: 1 + 2 + 3 + 4 = 10 with a 3-cycle en drop.
        q.push_back(mk(lanes4(32'd10, 32'd10, 32'd10, 32'd10), 1'b0));
        do_start(16'd4);
        fork
            begin
                send_beat(in4(16'd1, 16'd1, 16'd1, 16'd1));
                send_beat(in4(16'd2, 16'd2, 16'd2, 16'd2));
                send_beat(in4(16'd3, 16'd3, 16'd3, 16'd3));
                send_beat(in4(16'd4, 16'd4, 16'd4, 16'd4));
            end
            begin
                repeat (2) @(negedge clk);
                en = 1'b0;
                repeat (3) @(negedge clk);
                en = 1'b1;
            end
        join
        #1;
        check("en_out_valid", 128'(out_valid), 128'(1));
        check("en_busy_done", 128'(busy), 128'(0));

        // Zero-length start is ignored.
        @(negedge clk);
        do_start(16'd0);
        repeat (2) @(negedge clk);
        #1;
        check("zero_len_busy", 128'(busy), 128'(0));
        check("zero_len_in_ready", 128'(in_ready), 128'(0));

        // Reset mid-job discards the partial sums.
        @(negedge clk);
        do_start(16'd4);
        send_beat(in4(16'd50, 16'd50, 16'd50, 16'd50));
        send_beat(in4(16'd50, 16'd50, 16'd50, 16'd50));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        q.push_back(mk(lanes4(32'd9, 32'd9, 32'd9, 32'd9), 1'b0));
        do_start(16'd1);
        send_beat(in4(16'd9, 16'd9, 16'd9, 16'd9));

        // Saturation on the 18-bit instance: 6 x 0x7FFF clamps lane0, lane1 sums to 6.
        q18.push_back(mk(lanes18(18'h1FFFF, 18'd6, 18'd0, 18'd0), 1'b1));
        s_start   = 1'b1;
        s_cfg_len = 16'd6;
        @(negedge clk);
        s_start   = 1'b0;
        repeat (6) s_send_beat(in4(16'h7FFF, 16'd1, 16'd0, 16'd0));

        repeat (5) @(negedge clk);
        check("q_drain", 128'(q.size()), 128'(0));
        check("q18_drain", 128'(q18.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe18_psum_accum.md
Name: pe18_psum_accum

Overview:
- Downstream drain stage for one column of the 1x8 (pe_parallel 2x2) PE array.
- Consumes the packed 64-bit MAC result of the bottom PE (four signed 16-bit lanes = 2 pixels x 2 weights).
- Accumulates the lanes over a programmed number of input-channel beats into four saturating 32-bit partial sums.
- Hands the finished sums to the writeback path over a valid/ready interface.

Parameters:
- LANES, 4, number of packed signed lanes (pe_parallel_pixel_18 * pe_parallel_weight_18)
- IN_W, 16, width of each input lane (pixel_width_18)
- ACC_W, 32, width of each accumulator lane, signed
- CNT_W, 16, width of beat counter and cfg_len

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  array-wide enable; when low, no input beat is accepted
- start  in  1  one-cycle pulse; begins a job using cfg_len
- cfg_len  in  CNT_W  beats per job, unsigned; sampled on an accepted start
- in_valid  in  1  pe_out beat valid
- in_ready  out  1  block accepts a beat this cycle
- pe_out  in  LANES*IN_W  packed lanes; lane i = bits [i*IN_W +: IN_W], signed two's complement
- out_valid  out  1  out_data/out_ovf hold a finished job
- out_ready  in  1  consumer takes the result
- out_data  out  LANES*ACC_W  packed accumulated lanes, same lane order as pe_out
- out_ovf  out  1  at least one lane saturated during the job
- busy  out  1  state is ACC

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - accumulators, cnt, len_q = 0
  - in_ready = 0, out_valid = 0, out_data = 0, out_ovf = 0, busy = 0
  - reset mid-job discards the partial sums and any pending result.
- IDLE:
  - start=1 with cfg_len != 0: latch len_q = cfg_len, clear accumulators, cnt and the sticky sat flag; go to ACC next cycle.
  - start with cfg_len == 0 is ignored; state stays IDLE.
  - start is allowed while out_valid=1 from the previous job.
- ACC:
  - Beat accepted when in_valid & in_ready.
  - in_ready = en & (state==ACC) & !(cnt==len_q-1 & out_valid & !out_ready).
  - The final beat therefore stalls only while the previous result is still unconsumed.
  - On each accepted beat, for each lane: acc_i <= sat(acc_i + sext(lane_i)).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets the sticky sat flag.
  - Accepted non-final beat: cnt++.
  - Accepted final beat (cnt == len_q-1):
    - out_data <= the updated sums (this beat included); out_ovf <= sat flag OR this beat's clamp.
    - out_valid <= 1; state -> IDLE; accumulators cleared.
  - start during ACC is ignored.
- Latency: out_valid rises on the cycle after the final beat is accepted.
- Output handshake:
  - out_valid holds with out_data/out_ovf stable until out_valid & out_ready.
  - After a transfer, out_valid clears next cycle unless a new final beat loads in the same cycle; then out_valid stays 1 with the new data.
  - The handshake is independent of en.
- en low: no beats accepted; accumulators and cnt hold; output handshake continues.
- busy = (state==ACC).

Test Plan:
- Basic job:
  - Stimulus: cfg_len=3, start; beats with all lanes = +100, +200, -50; out_ready=1.
  - Response: one cycle after beat 3, out_valid=1; every lane = 250; out_ovf=0; state IDLE.
- Lane independence and sign extension:
  - Stimulus: cfg_len=2, lanes {0x7FFF, 0x8000, 0x0001, 0xFFFF} twice.
  - Response: lanes {65534, -65536, 2, -2}.
- Saturation:
  - Stimulus: ACC_W overridden to 18, cfg_len=6, lane0 = 0x7FFF each beat.
  - Response: lane0 = 131071; out_ovf=1; other lanes unaffected.
- Backpressure:
  - Stimulus: out_ready=0; job A (cfg_len=1, value 5); start job B (cfg_len=2, value 7) while A pending.
  - Response on job B:
    - B's first beat is accepted; in_ready=0 on B's final beat while A is pending.
    - out_data stays 5 until out_ready=1.
    - The next cycle B's final beat is accepted; out_data=14 on the following cycle.
- en gating and start corner cases:
  - Stimulus: cfg_len=4; drop en for 3 cycles mid-job while in_valid stays 1.
  - Response: exactly 4 beats are counted and the sum is correct.
  - Stimulus: start with cfg_len=0.
  - Response: stays IDLE, busy=0.
- Reset mid-job:
  - Stimulus: assert reset after 2 of 4 beats, then run a fresh job with cfg_len=1, value 9.
  - Response: out_data lane = 9; no stale contribution from the aborted job.
